// File: rtl/coin_defs.sv
// Shared definitions for the coin pulse conditioner: channel indices, issue-FSM
// state encodings and default timing parameters.
package coin_defs;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_N   = 0;
  localparam int unsigned CH_D   = 1;
  localparam int unsigned CH_Q   = 2;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_GAP_CYCLES      = 2;
  localparam int unsigned DEF_CNT_W           = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } issue_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot channel: 2-flop synchroniser, stability counter, debounced level and
// a single-cycle strobe on an accepted 0->1 transition of the debounced level.
module coin_debounce
  import coin_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count only while the synchronised input disagrees with the accepted level, so
  // any return to the old level (bounce) restarts the qualification window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise    = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        rise    = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin front end: debounces the N/D/Q slot switches, latches each insertion as a pending
// flag and issues them one at a time (Q > D > N) as gap-spaced single-cycle pulses.
module coin_pulse_conditioner
  import coin_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic coin_n_raw,
  input  logic coin_d_raw,
  input  logic coin_q_raw,
  input  logic accept_en,
  output logic N,
  output logic D,
  output logic Q,
  output logic coin_reject,
  output logic busy
);

  localparam logic [CNT_W-1:0] GapLoad = CNT_W'(GAP_CYCLES);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] accepted, overrun, clear;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic              reject_q, reject_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  issue_state_e      state_q, state_d;

  assign raw_vec = {coin_q_raw, coin_d_raw, coin_n_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_vec[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pulse_d = '0;
    clear   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          if (pending_q[CH_Q]) begin
            clear[CH_Q] = 1'b1;
          end else if (pending_q[CH_D]) begin
            clear[CH_D] = 1'b1;
          end else begin
            clear[CH_N] = 1'b1;
          end
          pulse_d = clear;
          gap_d   = GapLoad;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - CNT_W'(1);
        if (gap_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe on a flag being issued this cycle re-arms it rather than counting as overrun.
    accepted  = rise & {NUM_CH{accept_en}};
    overrun   = accepted & pending_q & ~clear;
    pending_d = (pending_q & ~clear) | accepted;
    reject_d  = (|(rise & ~{NUM_CH{accept_en}})) | (|overrun);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      reject_q  <= reject_d;
    end
  end

  assign N           = pulse_q[CH_N];
  assign D           = pulse_q[CH_D];
  assign Q           = pulse_q[CH_Q];
  assign coin_reject = reject_q;
  assign busy        = (|pending_q) | (state_q == ST_GAP);

endmodule
